// File: rtl/md5_pad.sv
// MD5 message pre-processor: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and bit length.
// Optional MD5_PAD_BE_EN selects big-endian byte and length packing for SHA-family reuse.
module md5_pad #(
  parameter int unsigned LEN_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        din_i,
  input  logic              din_valid_i,
  input  logic              din_last_i,
  input  logic              flush_i,
  output logic              din_ready_o,
  output logic [15:0][31:0] M_o,
  output logic              blk_valid_o,
  output logic              blk_last_o,
  input  logic              blk_ready_i,
  output logic              err_o
);

  typedef enum logic [1:0] {FILL, OUT, EXTRA} state_t;
  typedef enum logic [1:0] {NONE, LENONLY, PAD80} pend_t;

  state_t              state, state_n;
  pend_t               pend, pend_n;
  logic [5:0]          b, b_n;
  logic [LEN_W-1:0]    cnt, cnt_n;
  logic [15:0][31:0]   m_n;
  logic                last_n, err_n, valid_n;
  logic                term;
  logic [6:0]          p;

  // Place one byte at block position idx; unwritten bytes stay zero because M_o is cleared per block.
  function automatic logic [15:0][31:0] put_byte(input logic [15:0][31:0] m,
                                                 input logic [5:0] idx,
                                                 input logic [7:0] v);
    logic [15:0][31:0] r;
    logic [4:0]        sh;
    r = m;
`ifdef MD5_PAD_BE_EN
    sh = {~idx[1:0], 3'b000};
`else
    sh = {idx[1:0], 3'b000};
`endif
    r[idx[5:2]][sh +: 8] = v;
    return r;
  endfunction

  function automatic logic [15:0][31:0] put_len(input logic [15:0][31:0] m,
                                                input logic [LEN_W-1:0] c);
    logic [15:0][31:0] r;
    logic [63:0]       len;
    r   = m;
    len = 64'({c, 3'b000});
`ifdef MD5_PAD_BE_EN
    r[14] = len[63:32];
    r[15] = len[31:0];
`else
    r[14] = len[31:0];
    r[15] = len[63:32];
`endif
    return r;
  endfunction

  assign din_ready_o = (state == FILL);

  // Next-state, packing and padding decisions.
  always_comb begin
    state_n = state;
    pend_n  = pend;
    b_n     = b;
    cnt_n   = cnt;
    m_n     = M_o;
    last_n  = blk_last_o;
    err_n   = err_o;
    term    = 1'b0;
    p       = 7'(b);
    case (state)
      FILL: begin
        term = flush_i || (din_valid_i && din_last_i);
        if (din_valid_i) begin
          m_n = put_byte(m_n, b, din_i);
          if (&cnt) err_n = 1'b1;
          else      cnt_n = cnt + LEN_W'(1);
        end
        p = 7'(b) + 7'(din_valid_i);
        if (term) begin
          b_n     = '0;
          state_n = OUT;
          if (p <= 7'd55) begin
            m_n    = put_byte(m_n, p[5:0], 8'h80);
            m_n    = put_len(m_n, cnt_n);
            last_n = 1'b1;
            pend_n = NONE;
          end else if (p <= 7'd63) begin
            m_n    = put_byte(m_n, p[5:0], 8'h80);
            last_n = 1'b0;
            pend_n = LENONLY;
          end else begin
            last_n = 1'b0;
            pend_n = PAD80;
          end
        end else if (din_valid_i) begin
          if (b == 6'd63) begin
            b_n     = '0;
            state_n = OUT;
            last_n  = 1'b0;
          end else begin
            b_n = b + 6'd1;
          end
        end
      end
      OUT: begin
        if (blk_ready_i) begin
          if (pend == NONE) begin
            state_n = FILL;
            m_n     = '0;
            b_n     = '0;
            last_n  = 1'b0;
            if (blk_last_o) cnt_n = '0;
          end else begin
            state_n = EXTRA;
          end
        end
      end
      EXTRA: begin
        m_n = '0;
        if (pend == PAD80) m_n = put_byte(m_n, 6'd0, 8'h80);
        m_n     = put_len(m_n, cnt);
        last_n  = 1'b1;
        pend_n  = NONE;
        state_n = OUT;
      end
      default: state_n = FILL;
    endcase
    valid_n = (state_n == OUT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= FILL;
      pend        <= NONE;
      b           <= '0;
      cnt         <= '0;
      M_o         <= '0;
      blk_valid_o <= 1'b0;
      blk_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      pend        <= pend_n;
      b           <= b_n;
      cnt         <= cnt_n;
      M_o         <= m_n;
      blk_valid_o <= valid_n;
      blk_last_o  <= last_n;
      err_o       <= err_n;
    end
  end

endmodule

// File: tb/tb_md5_pad.sv
// Directed self-checking bench for md5_pad; expectations follow MD5_PAD_BE_EN when it is defined.
module tb_md5_pad;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        din = '0;
  logic              din_valid = 1'b0;
  logic              din_last = 1'b0;
  logic              flush = 1'b0;
  logic              din_ready;
  logic [15:0][31:0] m;
  logic              blk_valid;
  logic              blk_last;
  logic              blk_ready = 1'b1;
  logic              err;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_w [16];

  md5_pad #(.LEN_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
    .din_last_i(din_last), .flush_i(flush), .din_ready_o(din_ready),
    .M_o(m), .blk_valid_o(blk_valid), .blk_last_o(blk_last),
    .blk_ready_i(blk_ready), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w4(input logic [7:0] b0, b1, b2, b3);
`ifdef MD5_PAD_BE_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  function automatic logic [31:0] len_w(input int idx, input logic [63:0] bits);
`ifdef MD5_PAD_BE_EN
    return (idx == 14) ? bits[63:32] : bits[31:0];
`else
    return (idx == 14) ? bits[31:0] : bits[63:32];
`endif
  endfunction

  task automatic clear_exp();
    for (int w = 0; w < 16; w++) exp_w[w] = '0;
  endtask

  // Drive one byte and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] v, input logic last);
    int n = 0;
    din = v; din_valid = 1'b1; din_last = last;
    while (din_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: din_ready stuck at %b, required 1", din_ready);
    end
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (blk_valid !== 1'b1 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      compared++; mismatched++;
      $display("FAIL valid_timeout: blk_valid %b, required 1", blk_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if (m !== '0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || err !== 1'b0 || din_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state: m=%h valid=%b last=%b err=%b ready=%b, required 0/0/0/0/1",
               m, blk_valid, blk_last, err, din_ready);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc(input string name);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    compared++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_latency: valid=%b last=%b, required 1/1", name, blk_valid, blk_last);
    end
    clear_exp();
    exp_w[0]  = w4(8'h61, 8'h62, 8'h63, 8'h80);
    exp_w[14] = len_w(14, 64'd24);
    exp_w[15] = len_w(15, 64'd24);
    for (int w = 0; w < 16; w++) begin
      compared++;
      if (m[w] !== exp_w[w]) begin
        mismatched++;
        $display("FAIL %s_M[%0d]: got %h, required %h", name, w, m[w], exp_w[w]);
      end
    end
    @(posedge clk); #1;
    compared++;
    if (blk_valid !== 1'b0 || din_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_after: valid=%b ready=%b, required 0/1", name, blk_valid, din_ready);
    end
  endtask

  task automatic test_empty();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    clear_exp();
    exp_w[0] = w4(8'h80, 8'h00, 8'h00, 8'h00);
    compared++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      mismatched++;
      $display("FAIL empty_flags: valid=%b last=%b, required 1/1", blk_valid, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      compared++;
      if (m[w] !== exp_w[w]) begin
        mismatched++;
        $display("FAIL empty_M[%0d]: got %h, required %h", w, m[w], exp_w[w]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_only();
    for (int i = 0; i < 56; i++) send_byte(8'h00, i == 55);
    clear_exp();
    exp_w[14] = w4(8'h80, 8'h00, 8'h00, 8'h00);
    compared++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b0) begin
      mismatched++;
      $display("FAIL b56_blk1_flags: valid=%b last=%b, required 1/0", blk_valid, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      compared++;
      if (m[w] !== exp_w[w]) begin
        mismatched++;
        $display("FAIL b56_blk1_M[%0d]: got %h, required %h", w, m[w], exp_w[w]);
      end
    end
    @(posedge clk); #1;
    compared++;
    if (blk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b56_gap: valid=%b, required 0", blk_valid);
    end
    @(posedge clk); #1;
    clear_exp();
    exp_w[14] = len_w(14, 64'd448);
    exp_w[15] = len_w(15, 64'd448);
    compared++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      mismatched++;
      $display("FAIL b56_blk2_flags: valid=%b last=%b, required 1/1", blk_valid, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      compared++;
      if (m[w] !== exp_w[w]) begin
        mismatched++;
        $display("FAIL b56_blk2_M[%0d]: got %h, required %h", w, m[w], exp_w[w]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pad80();
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
    for (int w = 0; w < 16; w++) exp_w[w] = w4(8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3));
    compared++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b0) begin
      mismatched++;
      $display("FAIL b64_blk1_flags: valid=%b last=%b, required 1/0", blk_valid, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      compared++;
      if (m[w] !== exp_w[w]) begin
        mismatched++;
        $display("FAIL b64_blk1_M[%0d]: got %h, required %h", w, m[w], exp_w[w]);
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_exp();
    exp_w[0]  = w4(8'h80, 8'h00, 8'h00, 8'h00);
    exp_w[14] = len_w(14, 64'd512);
    exp_w[15] = len_w(15, 64'd512);
    compared++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      mismatched++;
      $display("FAIL b64_blk2_flags: valid=%b last=%b, required 1/1", blk_valid, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      compared++;
      if (m[w] !== exp_w[w]) begin
        mismatched++;
        $display("FAIL b64_blk2_M[%0d]: got %h, required %h", w, m[w], exp_w[w]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    blk_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 70; i++) send_byte(8'(i + 1), i == 69);
      end
      begin
        logic [15:0][31:0] snap;
        for (int k = 0; k < 2; k++) begin
          wait_valid();
          snap = m;
          repeat (5) begin
            @(posedge clk); #1;
            compared++;
            if (m !== snap || din_ready !== 1'b0 || blk_valid !== 1'b1) begin
              mismatched++;
              $display("FAIL b70_hold%0d: stable=%b ready=%b valid=%b, required 1/0/1",
                       k, m === snap, din_ready, blk_valid);
            end
          end
          clear_exp();
          if (k == 0) begin
            for (int w = 0; w < 16; w++) exp_w[w] = w4(8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4));
          end else begin
            exp_w[0]  = w4(8'd65, 8'd66, 8'd67, 8'd68);
            exp_w[1]  = w4(8'd69, 8'd70, 8'h80, 8'h00);
            exp_w[14] = len_w(14, 64'd560);
            exp_w[15] = len_w(15, 64'd560);
          end
          compared++;
          if (blk_last !== (k == 1)) begin
            mismatched++;
            $display("FAIL b70_last%0d: got %b, required %b", k, blk_last, k == 1);
          end
          for (int w = 0; w < 16; w++) begin
            compared++;
            if (m[w] !== exp_w[w]) begin
              mismatched++;
              $display("FAIL b70_blk%0d_M[%0d]: got %h, required %h", k, w, m[w], exp_w[w]);
            end
          end
          blk_ready = 1'b1;
          @(posedge clk); #1;
          blk_ready = 1'b0;
        end
      end
    join
    blk_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) send_byte(8'h11, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    compared++;
    if (m !== '0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || err !== 1'b0 || din_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid: m=%h valid=%b last=%b err=%b ready=%b, required 0/0/0/0/1",
               m, blk_valid, blk_last, err, din_ready);
    end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    test_abc("abc_after_rst");
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_empty();
    test_len_only();
    test_pad80();
    test_back_to_back();
    test_reset_mid();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_flag: got %b, required 0", err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/md5_pad.md
Name: md5_pad

Overview:
- Message pre-processor directly upstream of the MD5 compression core.
- Accepts a byte stream and packs it into 512-bit blocks of 16 x 32-bit words, little-endian as MD5 requires.
- Appends the 0x80 marker, zero fill and the 64-bit message bit-length, producing one or two final blocks.
- Presents each block on a valid/ready handshake for the core to consume as its M input.

Parameters:
LEN_W, 32, width of the message byte counter; maximum message length is 2^LEN_W-1 bytes.

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  asynchronous, active-low reset
din_i  input  8  message byte
din_valid_i  input  1  din_i valid
din_last_i  input  1  qualifies din_i as the final byte of the message
flush_i  input  1  terminate the message with the bytes accepted so far; used for empty messages
din_ready_o  output  1  byte/flush accepted when high with din_valid_i or flush_i
M_o  output  16x32  block words M_o[0..15], word 0 first
blk_valid_o  output  1  M_o holds a complete block
blk_last_o  output  1  current block is the final block of the message
blk_ready_i  input  1  consumer takes the block when high with blk_valid_o
err_o  output  1  sticky length-overflow flag

Behaviour:
- Reset (rst_i low, async) forces the following:
  - state FILL, byte index b=0, byte count cnt=0, pending=NONE;
  - M_o all zero, blk_valid_o=0, blk_last_o=0, err_o=0.
  - din_ready_o = (state==FILL), so it reads 1 after reset.
- States: FILL, OUT, EXTRA.
- FILL state:
  - Accepted byte goes to M_o[b>>2] bits [8*(b%4)+7 : 8*(b%4)]; then b++ and cnt++.
  - If cnt would wrap: err_o<=1 and cnt saturates.
  - b==63 accepted without last: go to OUT, blk_last_o=0, b<=0.
- Termination event: din_last_i accepted (byte included), or flush_i with no byte. flush_i together with din_valid_i is identical to din_last_i. Let p = byte position after data.
  - p<=55: byte p=0x80, bytes p+1..55 = 0, words 14/15 = {cnt,3'b000} zero-extended to 64 bits (word 14 = low 32 bits). Go to OUT, blk_last_o=1.
  - 56<=p<=63: byte p=0x80, rest zero. Go to OUT, blk_last_o=0, pending=LENONLY.
  - p==64 (final byte at index 63): go to OUT, blk_last_o=0, pending=PAD80.
  - Empty message (flush_i, cnt==0, b==0): M_o[0]=0x00000080, rest 0, length 0, blk_last_o=1.
- Padding is written in the same cycle as the terminating accept. blk_valid_o rises on the next cycle, giving 1-cycle latency from the final accept.
- OUT state:
  - blk_valid_o=1 and din_ready_o=0; M_o and blk_last_o are held stable until blk_ready_i.
  - On handshake with pending==NONE: go to FILL, M_o cleared, b=0. If blk_last_o, cnt=0 and err_o is kept.
  - On handshake with pending!=NONE: go to EXTRA.
- EXTRA state: one cycle, blk_valid_o=0. Builds the second block:
  - PAD80: M_o[0]=0x80, zeros, length.
  - LENONLY: all zero, length.
  - Then OUT with blk_last_o=1 and pending=NONE.
- din_valid_i in OUT/EXTRA is ignored; the producer holds the byte.
- Reset mid-message discards the partial block and count immediately.

Optional Feature:
MD5_PAD_BE_EN
- Defined: big-endian packing for SHA-family reuse.
  - Byte b goes to bits [31-8*(b%4) : 24-8*(b%4)].
  - Length is big-endian: word 14 = high 32 bits, word 15 = low 32 bits.
- Undefined: little-endian MD5 packing as above.

Test Plan:
- "abc" (0x61,0x62,0x63 with last on 0x63), blk_ready_i=1 → one block, blk_last_o=1, M_o[0]=0x80636261, M_o[1..13]=0, M_o[14]=0x00000018, M_o[15]=0; blk_valid_o one cycle after the last accept.
- flush_i after reset with no bytes → M_o[0]=0x00000080, M_o[1..15]=0, blk_last_o=1.
- 56 bytes of 0x00, last on byte 55:
  - block 1: M_o[14]=0x00000080, M_o[15]=0, blk_last_o=0;
  - EXTRA gap of one cycle;
  - block 2: M_o[0..13]=0, M_o[14]=0x000001C0, blk_last_o=1.
- 64 bytes, last on byte 63:
  - block 1: data only, blk_last_o=0;
  - block 2: M_o[0]=0x80, M_o[14]=0x00000200, blk_last_o=1.
- 70-byte message with blk_ready_i held low 5 cycles at each block → M_o stable and din_ready_o=0 while blocked; the 70 bytes are split across two blocks with no loss; rst_i pulsed low mid-block → outputs 0 asynchronously, next "abc" yields the single-block result above.
- MD5_PAD_BE_EN defined, "abc" → M_o[0]=0x61626380, M_o[14]=0, M_o[15]=0x00000018.
